// File: rtl/ahb_subordinate_mem_if.sv
// rtl/ahb_subordinate_mem_if.sv - AHB5 manager/subordinate signal bundle for ahb_subordinate_mem
interface ahb_subordinate_mem_if #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int HMASTER_WIDTH = 4
);
    logic                     HSEL;
    logic [ADDR_WIDTH-1:0]    HADDR;
    logic [1:0]               HTRANS;
    logic                     HWRITE;
    logic [2:0]               HSIZE;
    logic [2:0]               HBURST;
    logic [3:0]               HPROT;
    logic [HMASTER_WIDTH-1:0] HMASTER;
    logic                     HEXCL;
    logic [DATA_WIDTH-1:0]    HWDATA;
    logic [DATA_WIDTH/8-1:0]  HWSTRB;
    logic                     HREADY;
    logic                     HREADYOUT;
    logic                     HRESP;
    logic [DATA_WIDTH-1:0]    HRDATA;
    logic                     HEXOKAY;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTER, HEXCL,
               HWDATA, HWSTRB, HREADY,
        input  HREADYOUT, HRESP, HRDATA, HEXOKAY
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTER, HEXCL,
               HWDATA, HWSTRB, HREADY,
        output HREADYOUT, HRESP, HRDATA, HEXOKAY
    );
endinterface

// File: rtl/ahb_subordinate_mem.sv
// rtl/ahb_subordinate_mem.sv - AHB5 memory subordinate with wait states and ERROR response
// Optional exclusive-access monitor enabled by defining AHB_SUB_EXCL_MON_EN.
module ahb_subordinate_mem #(
    parameter int                    ADDR_WIDTH    = 32,
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    HMASTER_WIDTH = 4,
    parameter int                    MEM_DEPTH     = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
    parameter int                    WAIT_STATES   = 0
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    ahb_subordinate_mem_if.slave bus
);
    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int LANE_W = $clog2(BYTES);
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int OFF_W  = LANE_W + IDX_W;
    localparam logic [ADDR_WIDTH:0] REGION_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH * BYTES);
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t                   state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic [OFF_W-1:0]         off_q, off_d;
    logic                     write_q, write_d;
    logic [2:0]               size_q, size_d;
    logic                     excl_q, excl_d;
    logic [HMASTER_WIDTH-1:0] master_q, master_d;
    logic [DATA_WIDTH-1:0]    mem [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0]    offset;
    logic [7:0]               align_mask;
    logic                     hready_out, accept, illegal, commit, excl_ok;
    state_t                   accept_state;
    logic [IDX_W-1:0]         idx;
    logic [BYTES-1:0]         size_mask, lane_we;
    logic                     unused_bus;

    // Addresses below BASE_ADDR wrap to a huge offset and fail the range test.
    assign offset       = bus.HADDR - BASE_ADDR;
    assign align_mask   = 8'((9'd1 << bus.HSIZE) - 9'd1);
    assign illegal      = ({1'b0, offset} >= REGION_BYTES) || (32'(bus.HSIZE) > LANE_W)
                          || (|(bus.HADDR[7:0] & align_mask));
    assign hready_out   = (state_q != S_WAIT) && (state_q != S_ERR1);
    assign accept       = bus.HSEL && bus.HREADY && bus.HTRANS[1] && hready_out;
    assign accept_state = illegal ? S_ERR1 : ((WAIT_STATES > 0) ? S_WAIT : S_DATA);
    assign idx          = off_q[OFF_W-1:LANE_W];
    assign unused_bus   = ^{offset[ADDR_WIDTH-1:OFF_W], bus.HTRANS[0], bus.HBURST, bus.HPROT};

    always_comb begin
        size_mask = '0;
        for (int i = 0; i < BYTES; i++) begin
            size_mask[i] = ((i >> size_q) == (32'(off_q[LANE_W-1:0]) >> size_q));
        end
    end

`ifdef AHB_SUB_EXCL_MON_EN
    logic                     resv_valid_q, resv_valid_d;
    logic [HMASTER_WIDTH-1:0] resv_master_q, resv_master_d;
    logic [IDX_W-1:0]         resv_idx_q, resv_idx_d;
    logic                     resv_hit;

    assign resv_hit = resv_valid_q && (resv_master_q == master_q) && (resv_idx_q == idx);
    assign excl_ok  = excl_q && (!write_q || resv_hit);
    assign commit   = (state_q == S_DATA) && write_q && (!excl_q || resv_hit);

    always_comb begin
        resv_valid_d  = resv_valid_q;
        resv_master_d = resv_master_q;
        resv_idx_d    = resv_idx_q;
        if (state_q == S_DATA) begin
            if (excl_q && !write_q) begin
                resv_valid_d  = 1'b1;
                resv_master_d = master_q;
                resv_idx_d    = idx;
            end else if (excl_q && resv_hit) begin
                resv_valid_d = 1'b0;
            end else if (commit && (master_q != resv_master_q) && (idx == resv_idx_q)) begin
                resv_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            resv_valid_q  <= 1'b0;
            resv_master_q <= '0;
            resv_idx_q    <= '0;
        end else begin
            resv_valid_q  <= resv_valid_d;
            resv_master_q <= resv_master_d;
            resv_idx_q    <= resv_idx_d;
        end
    end
`else
    logic unused_excl;
    assign excl_ok     = 1'b0;
    assign commit      = (state_q == S_DATA) && write_q;
    assign unused_excl = ^{excl_q, master_q};
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        off_d    = off_q;
        write_d  = write_q;
        size_d   = size_q;
        excl_d   = excl_q;
        master_d = master_q;
        if (accept) begin
            off_d    = offset[OFF_W-1:0];
            write_d  = bus.HWRITE;
            size_d   = bus.HSIZE;
            excl_d   = bus.HEXCL;
            master_d = bus.HMASTER;
            cnt_d    = WAIT_LOAD;
        end
        case (state_q)
            S_IDLE, S_DATA, S_ERR2: state_d = accept ? accept_state : S_IDLE;
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_DATA;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            off_q    <= '0;
            write_q  <= 1'b0;
            size_q   <= '0;
            excl_q   <= 1'b0;
            master_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            off_q    <= off_d;
            write_q  <= write_d;
            size_q   <= size_d;
            excl_q   <= excl_d;
            master_q <= master_d;
        end
    end

    // Commit happens on the edge that closes DATA, ahead of any pipelined read's data phase.
    assign lane_we = commit ? (bus.HWSTRB & size_mask) : '0;

    always_ff @(posedge HCLK) begin
        if (!HRESET) begin
            for (int i = 0; i < BYTES; i++) begin
                if (lane_we[i]) mem[idx][8*i +: 8] <= bus.HWDATA[8*i +: 8];
            end
        end
    end

    assign bus.HREADYOUT = hready_out;
    assign bus.HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
    assign bus.HRDATA    = ((state_q == S_DATA) && !write_q) ? mem[idx] : '0;
    assign bus.HEXOKAY   = (state_q == S_DATA) && excl_ok;
endmodule

// File: tb/tb_ahb_subordinate_mem.sv
// tb/tb_ahb_subordinate_mem.sv - directed vector bench for ahb_subordinate_mem (wait states 0, 3, 5)
`timescale 1ns/1ps
module tb_ahb_subordinate_mem;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        hsel, hwrite, hexcl;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot, hmaster, hwstrb;
    logic [1:0]  sel;

    logic        rdy_v [3];
    logic        resp_v [3];
    logic        exok_v [3];
    logic [31:0] rdata_v [3];
    logic        rdy, resp, exok_s;
    logic [31:0] rdata;

    ahb_subordinate_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .HMASTER_WIDTH(4)) bus [3] ();

    for (genvar k = 0; k < 3; k++) begin : g_dut
        assign bus[k].HSEL    = hsel && (sel == 2'(k));
        assign bus[k].HADDR   = haddr;
        assign bus[k].HTRANS  = htrans;
        assign bus[k].HWRITE  = hwrite;
        assign bus[k].HSIZE   = hsize;
        assign bus[k].HBURST  = hburst;
        assign bus[k].HPROT   = hprot;
        assign bus[k].HMASTER = hmaster;
        assign bus[k].HEXCL   = hexcl;
        assign bus[k].HWDATA  = hwdata;
        assign bus[k].HWSTRB  = hwstrb;
        assign bus[k].HREADY  = bus[k].HREADYOUT;
        assign rdy_v[k]       = bus[k].HREADYOUT;
        assign resp_v[k]      = bus[k].HRESP;
        assign exok_v[k]      = bus[k].HEXOKAY;
        assign rdata_v[k]     = bus[k].HRDATA;

        ahb_subordinate_mem #(
            .ADDR_WIDTH(32), .DATA_WIDTH(32), .HMASTER_WIDTH(4), .MEM_DEPTH(256),
            .BASE_ADDR(32'h0), .WAIT_STATES((k == 0) ? 0 : ((k == 1) ? 3 : 5))
        ) u_dut (
            .HCLK(clk),
            .HRESET(rst),
            .bus(bus[k])
        );
    end

    assign rdy    = rdy_v[sel];
    assign resp   = resp_v[sel];
    assign exok_s = exok_v[sel];
    assign rdata  = rdata_v[sel];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, {31'b0, act}, {31'b0, exp});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        hsel   = 1'b0;
        htrans = 2'b00;
    endtask

    task automatic addr_phase(input logic [1:0] tr, input logic [31:0] a, input logic w, input logic [2:0] sz);
        hsel   = 1'b1;
        htrans = tr;
        haddr  = a;
        hwrite = w;
        hsize  = sz;
    endtask

    // Single NONSEQ transfer; returns after the completing data-phase cycle, so a following call pipelines.
    task automatic xfer(input logic [31:0] a, input logic w, input logic [2:0] sz, input logic [31:0] wd,
                        input logic [3:0] st, output logic err1, output logic rsp, output logic [31:0] rd,
                        output int waits, output logic ex, output int bad);
        int n;
        addr_phase(2'b10, a, w, sz);
        step();
        idle_bus();
        hwdata = wd;
        hwstrb = st;
        err1 = 1'b0; waits = 0; bad = 0; n = 0;
        while (!rdy && n < 40) begin
            if (resp) err1 = 1'b1;
            if (rdata !== 32'h0) bad++;
            waits++;
            n++;
            step();
        end
        check1("xfer_completes", rdy, 1'b1);
        rsp = resp;
        rd  = rdata;
        ex  = exok_s;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vt [23];

    initial begin
        logic        err1, rsp, ex;
        logic [31:0] rd;
        int          w, bad, low_cnt, resp_cnt;

        vt[0]  = '{32'h010, 1'b1, 3'd2, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0};
        vt[1]  = '{32'h010, 1'b0, 3'd2, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF};
        vt[2]  = '{32'h010, 1'b1, 3'd2, 32'h11223344, 4'hF, 1'b0, 32'h0};
        vt[3]  = '{32'h013, 1'b1, 3'd0, 32'hAA000000, 4'hF, 1'b0, 32'h0};
        vt[4]  = '{32'h010, 1'b0, 3'd2, 32'h0,        4'h0, 1'b0, 32'hAA223344};
        vt[5]  = '{32'h014, 1'b1, 3'd2, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0};
        vt[6]  = '{32'h016, 1'b1, 3'd1, 32'h55660000, 4'hF, 1'b0, 32'h0};
        vt[7]  = '{32'h014, 1'b0, 3'd2, 32'h0,        4'h0, 1'b0, 32'h5566F00D};
        vt[8]  = '{32'h018, 1'b1, 3'd2, 32'h00000000, 4'hF, 1'b0, 32'h0};
        vt[9]  = '{32'h018, 1'b1, 3'd2, 32'hFFFFFFFF, 4'h5, 1'b0, 32'h0};
        vt[10] = '{32'h018, 1'b0, 3'd2, 32'h0,        4'h0, 1'b0, 32'h00FF00FF};
        vt[11] = '{32'h000, 1'b1, 3'd2, 32'h12345678, 4'hF, 1'b0, 32'h0};
        vt[12] = '{32'h002, 1'b1, 3'd2, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0};
        vt[13] = '{32'h400, 1'b1, 3'd2, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0};
        vt[14] = '{32'h020, 1'b0, 3'd3, 32'h0,        4'h0, 1'b1, 32'h0};
        vt[15] = '{32'h000, 1'b0, 3'd2, 32'h0,        4'h0, 1'b0, 32'h12345678};
        vt[16] = '{32'h3FC, 1'b1, 3'd2, 32'hA5A5A5A5, 4'hF, 1'b0, 32'h0};
        vt[17] = '{32'h3FC, 1'b0, 3'd2, 32'h0,        4'h0, 1'b0, 32'hA5A5A5A5};
        vt[18] = '{32'h3FF, 1'b0, 3'd0, 32'h0,        4'h0, 1'b0, 32'hA5A5A5A5};
        vt[19] = '{32'h3FE, 1'b1, 3'd1, 32'h12340000, 4'hF, 1'b0, 32'h0};
        vt[20] = '{32'h3FC, 1'b0, 3'd2, 32'h0,        4'h0, 1'b0, 32'h1234A5A5};
        vt[21] = '{32'h401, 1'b0, 3'd0, 32'h0,        4'h0, 1'b1, 32'h0};
        vt[22] = '{32'h011, 1'b1, 3'd1, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0};

        rst = 1'b1; sel = 2'd0; hsel = 1'b0; htrans = 2'b00; haddr = '0; hwrite = 1'b0;
        hsize = 3'd2; hburst = 3'd0; hprot = 4'h3; hmaster = 4'd0; hexcl = 1'b0;
        hwdata = '0; hwstrb = 4'h0;
        repeat (3) step();
        for (int k = 0; k < 3; k++) begin
            sel = 2'(k);
            #1;
            check1($sformatf("reset_hreadyout_%0d", k), rdy, 1'b1);
            check1($sformatf("reset_hresp_%0d", k), resp, 1'b0);
            check($sformatf("reset_hrdata_%0d", k), rdata, 32'h0);
            check1($sformatf("reset_hexokay_%0d", k), exok_s, 1'b0);
        end
        rst = 1'b0;
        sel = 2'd0;
        step();

        for (int i = 0; i < 23; i++) begin
            xfer(vt[i].addr, vt[i].wr, vt[i].size, vt[i].wdata, vt[i].strb, err1, rsp, rd, w, ex, bad);
            check1($sformatf("vec%0d_resp", i), rsp, vt[i].exp_err);
            check1($sformatf("vec%0d_err1", i), err1, vt[i].exp_err);
            check($sformatf("vec%0d_lowcycles", i), 32'(w), vt[i].exp_err ? 32'd1 : 32'd0);
            check($sformatf("vec%0d_hrdata", i), rd, vt[i].exp_rdata);
        end
        idle_bus();
        step();

        // INCR4 write burst 0x40..0x4C with a BUSY after the second beat
        low_cnt = 0; resp_cnt = 0; hburst = 3'b011; hwstrb = 4'hF;
        addr_phase(2'b10, 32'h40, 1'b1, 3'd2); step();
        if (!rdy) low_cnt++;
        hwdata = 32'h00004040; addr_phase(2'b11, 32'h44, 1'b1, 3'd2); step();
        if (!rdy) low_cnt++;
        if (resp) resp_cnt++;
        hwdata = 32'h00004444; addr_phase(2'b01, 32'h48, 1'b1, 3'd2); step();
        check1("busy_hreadyout", rdy, 1'b1);
        check1("busy_hresp", resp, 1'b0);
        hwdata = 32'hFFFFFFFF; addr_phase(2'b11, 32'h48, 1'b1, 3'd2); step();
        if (!rdy) low_cnt++;
        if (resp) resp_cnt++;
        hwdata = 32'h00004848; addr_phase(2'b11, 32'h4C, 1'b1, 3'd2); step();
        if (!rdy) low_cnt++;
        if (resp) resp_cnt++;
        hwdata = 32'h00004C4C; idle_bus(); step();
        check("burst_low_cycles", 32'(low_cnt), 32'd0);
        check("burst_err_cycles", 32'(resp_cnt), 32'd0);
        hburst = 3'd0;
        for (int i = 0; i < 4; i++) begin
            xfer(32'h40 + 32'(4 * i), 1'b0, 3'd2, 32'h0, 4'h0, err1, rsp, rd, w, ex, bad);
            check($sformatf("burst_read_%0d", i), rd, 32'h00004040 + 32'(i * 32'h0404));
        end
        idle_bus();
        step();

        // Three wait states, then a read pipelined into the previous read's final cycle
        sel = 2'd1;
        xfer(32'h20, 1'b1, 3'd2, 32'h0BADF00D, 4'hF, err1, rsp, rd, w, ex, bad);
        check("ws3_write_waits", 32'(w), 32'd3);
        check1("ws3_write_resp", rsp, 1'b0);
        xfer(32'h20, 1'b0, 3'd2, 32'h0, 4'h0, err1, rsp, rd, w, ex, bad);
        check("ws3_read_waits", 32'(w), 32'd3);
        check("ws3_read_data", rd, 32'h0BADF00D);
        check("ws3_wait_hrdata_zero", 32'(bad), 32'd0);
        xfer(32'h20, 1'b0, 3'd2, 32'h0, 4'h0, err1, rsp, rd, w, ex, bad);
        check("ws3_pipelined_waits", 32'(w), 32'd3);
        check("ws3_pipelined_data", rd, 32'h0BADF00D);
        idle_bus();
        step();

        // Reset asserted while a write sits in WAIT
        sel = 2'd2;
        xfer(32'h60, 1'b1, 3'd2, 32'h11111111, 4'hF, err1, rsp, rd, w, ex, bad);
        check("ws5_write_waits", 32'(w), 32'd5);
        addr_phase(2'b10, 32'h60, 1'b1, 3'd2); step();
        idle_bus(); hwdata = 32'h22222222; hwstrb = 4'hF; step(); step();
        check1("ws5_in_wait", rdy, 1'b0);
        rst = 1'b1; step();
        check1("midreset_hreadyout", rdy, 1'b1);
        check1("midreset_hresp", resp, 1'b0);
        check("midreset_hrdata", rdata, 32'h0);
        rst = 1'b0; step(); step();
        xfer(32'h60, 1'b0, 3'd2, 32'h0, 4'h0, err1, rsp, rd, w, ex, bad);
        check("midreset_word_unchanged", rd, 32'h11111111);
        check("midreset_read_waits", 32'(w), 32'd5);
        idle_bus();
        step();

        sel = 2'd0;
`ifdef AHB_SUB_EXCL_MON_EN
        hmaster = 4'd1; hexcl = 1'b1;
        xfer(32'h80, 1'b0, 3'd2, 32'h0, 4'h0, err1, rsp, rd, w, ex, bad);
        check1("excl_read_exokay", ex, 1'b1);
        xfer(32'h80, 1'b1, 3'd2, 32'hAAAA0001, 4'hF, err1, rsp, rd, w, ex, bad);
        check1("excl_write_exokay", ex, 1'b1);
        hexcl = 1'b0;
        xfer(32'h80, 1'b0, 3'd2, 32'h0, 4'h0, err1, rsp, rd, w, ex, bad);
        check("excl_write_landed", rd, 32'hAAAA0001);
        check1("plain_read_exokay", ex, 1'b0);
        hexcl = 1'b1;
        xfer(32'h80, 1'b0, 3'd2, 32'h0, 4'h0, err1, rsp, rd, w, ex, bad);
        check1("excl_reread_exokay", ex, 1'b1);
        hmaster = 4'd2; hexcl = 1'b0;
        xfer(32'h80, 1'b1, 3'd2, 32'hBBBB0002, 4'hF, err1, rsp, rd, w, ex, bad);
        hmaster = 4'd1; hexcl = 1'b1;
        xfer(32'h80, 1'b1, 3'd2, 32'hCCCC0003, 4'hF, err1, rsp, rd, w, ex, bad);
        check1("excl_fail_exokay", ex, 1'b0);
        check1("excl_fail_resp", rsp, 1'b0);
        hexcl = 1'b0;
        xfer(32'h80, 1'b0, 3'd2, 32'h0, 4'h0, err1, rsp, rd, w, ex, bad);
        check("excl_fail_suppressed", rd, 32'hBBBB0002);
`else
        hmaster = 4'd1; hexcl = 1'b1;
        xfer(32'h80, 1'b0, 3'd2, 32'h0, 4'h0, err1, rsp, rd, w, ex, bad);
        check1("nomon_read_exokay", ex, 1'b0);
        xfer(32'h80, 1'b1, 3'd2, 32'hAAAA0001, 4'hF, err1, rsp, rd, w, ex, bad);
        check1("nomon_write_exokay", ex, 1'b0);
        hexcl = 1'b0;
        xfer(32'h80, 1'b0, 3'd2, 32'h0, 4'h0, err1, rsp, rd, w, ex, bad);
        check("nomon_write_landed", rd, 32'hAAAA0001);
`endif
        idle_bus();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ahb_subordinate_mem.md
Name: ahb_subordinate_mem

Overview:
Synthesizable AHB5 subordinate that responds to a manager with an internal word-organised memory. It provides programmable wait states, the two-cycle ERROR response, byte-lane writes via HWSTRB and HSIZE, and optionally an exclusive-access monitor. It serves as the responder end of the AHB agent interface: the DUT-side target for master-agent tests and the reference RTL for slave-agent checks.

Parameters:
ADDR_WIDTH, 32, HADDR width
DATA_WIDTH, 32, HWDATA/HRDATA width; only 32 or 64 are legal
HMASTER_WIDTH, 4, manager ID width
MEM_DEPTH, 256, number of DATA_WIDTH words; power of 2
BASE_ADDR, 0, byte address of word 0; aligned to the region size
WAIT_STATES, 0, HREADYOUT-low cycles inserted per non-error data phase; 0..15

Ports:
HCLK  in  1  clock; all logic on the rising edge
HRESET  in  1  synchronous, active-high reset
HSEL  in  1  subordinate select
HADDR  in  ADDR_WIDTH  byte address
HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
HWRITE  in  1  1 = write
HSIZE  in  3  log2 of bytes per beat
HBURST  in  3  burst type; ignored apart from legality
HPROT  in  4  ignored
HMASTER  in  HMASTER_WIDTH  manager ID (exclusive monitor only)
HEXCL  in  1  exclusive access (exclusive monitor only)
HWDATA  in  DATA_WIDTH  write data, data phase
HWSTRB  in  DATA_WIDTH/8  write byte strobes, data phase
HREADY  in  1  combined bus ready
HREADYOUT  out  1  subordinate ready
HRESP  out  1  0 = OKAY, 1 = ERROR
HRDATA  out  DATA_WIDTH  read data
HEXOKAY  out  1  exclusive OKAY

Behaviour:
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, HEXOKAY=0; state IDLE; all registered address-phase fields cleared. Memory contents are not reset.
- Address-phase accept: HSEL & HREADY & HTRANS[1] at a rising edge. The block then registers addr, write, size, excl, master.
- HTRANS IDLE/BUSY, or HSEL=0 with HREADY=1: no transfer; the next cycle is zero-wait OKAY.
- Error check at accept; any of the following gives ERROR:
  - HADDR-BASE_ADDR >= MEM_DEPTH*DATA_WIDTH/8;
  - HSIZE > log2(DATA_WIDTH/8);
  - HADDR not aligned to HSIZE.
- States:
  - IDLE: HREADYOUT=1.
  - WAIT: HREADYOUT=0; a counter loads WAIT_STATES-1 and decrements.
  - DATA: final data-phase cycle, HREADYOUT=1.
  - ERR1: HRESP=1, HREADYOUT=0.
  - ERR2: HRESP=1, HREADYOUT=1.
- Transitions:
  - Accept, legal, WAIT_STATES>0: ->WAIT.
  - Accept, legal, WAIT_STATES=0: ->DATA.
  - Accept, illegal: ->ERR1.
  - WAIT with count 0: ->DATA.
  - ERR1: ->ERR2.
  - DATA or ERR2: go to the state chosen by a same-cycle new accept (pipelined, no bubble), else ->IDLE.
- Error path: the write is suppressed and HRDATA=0 in ERR1/ERR2. A new address sampled during ERR2 is accepted normally; the manager is responsible for driving IDLE there if it cancels.
- Write commit: at the rising edge ending DATA, only the lanes with HWSTRB[i] & sizemask[i] are written. sizemask is computed from the registered addr[log2(DATA_WIDTH/8)-1:0] and size.
- Read: in DATA, HRDATA = mem[word index]. HRDATA=0 in WAIT, IDLE and on writes.
- Back-to-back write then read of the same address returns the new data. Write commit precedes the read data phase, so no forwarding is needed.
- HSEL or HTRANS changes during WAIT are ignored; the registered transfer completes.
- HRESET asserted mid-transfer: the next cycle shows reset values, any in-flight write is dropped, and the state goes to IDLE.

Optional Feature:
Macro AHB_SUB_EXCL_MON_EN.
- Defined: a single reservation {valid, master, word address}.
  - Exclusive read: sets the reservation; HEXOKAY=1 in its DATA cycle.
  - Exclusive write with valid & master match & address match: commits, HEXOKAY=1, reservation cleared.
  - Exclusive write otherwise: suppressed, HEXOKAY=0, HRESP=OKAY.
  - Any committed write from another master to the reserved word clears the reservation.
  - ERROR transfers never touch the reservation.
- Undefined: HEXCL and HMASTER are ignored, exclusive writes commit normally, HEXOKAY is tied to 0.

Test Plan:
- WAIT_STATES=0: NONSEQ write 0x0000_0010 data 0xDEADBEEF HWSTRB=F, then read 0x10 -> HREADYOUT never low; read data phase HRDATA=0xDEADBEEF, HRESP=0.
- WAIT_STATES=3: single read of 0x20 -> HREADYOUT low for exactly 3 cycles, then high with data; next NONSEQ accepted on that same cycle.
- Byte write: HSIZE=0 to 0x13 with HWDATA=0xAA000000 over 0x11223344 -> read returns 0xAA223344; HWSTRB=F does not corrupt other lanes.
- Out-of-range address 0x400 (MEM_DEPTH=256), or HSIZE=2 at 0x02 -> ERR1 (HRESP=1, HREADYOUT=0) then ERR2 (1,1); memory unchanged; next transfer OKAY.
- INCR4 burst writes 0x40..0x4C with a BUSY inserted after beat 2 -> BUSY beat zero-wait OKAY; reads return all 4 words.
- With AHB_SUB_EXCL_MON_EN: master 1 excl read 0x80 then excl write -> HEXOKAY=1, write lands; repeat with master 2 normal write to 0x80 in between -> HEXOKAY=0, excl write suppressed.
- HRESET asserted during WAIT (WAIT_STATES=5) -> next cycle HREADYOUT=1, HRESP=0, target word unchanged.
